// File: rtl/handshake_sink_check.sv
// rtl/handshake_sink_check.sv - valid/ready sink with periodic backpressure, token counter and constant checker
module handshake_sink_check #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED     = 32'h77CBF1FA,
  parameter int                    NUM_TOKENS   = 16,
  parameter int                    CNT_WIDTH    = 16,
  parameter int                    READY_PERIOD = 4,
  parameter int                    READY_DUTY   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [CNT_WIDTH-1:0]  token_count,
  output logic                  mismatch,
  output logic [DATA_WIDTH-1:0] first_bad,
  output logic                  done
);

  localparam int PH_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  // A zero duty would leave the sink permanently stalled.
  if (READY_DUTY < 1) begin : g_bad_duty
    $error("handshake_sink_check: READY_DUTY must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [PH_W-1:0]       phase_q;
  logic [PH_W-1:0]       phase_d;
  logic [CNT_WIDTH-1:0]  token_count_q;
  logic [CNT_WIDTH-1:0]  token_count_d;
  logic                  mismatch_q;
  logic [DATA_WIDTH-1:0] first_bad_q;
  logic                  done_q;
  logic                  xfer;
  logic                  last_xfer;
  logic                  bad_token;

  // Ready depends on registered state only, so there is no path from ins_valid.
  assign ins_ready = (state_q == S_RUN) && (32'(phase_q) < READY_DUTY);
  assign xfer      = ins_valid && ins_ready;
  assign bad_token = (ins != EXPECTED);

  // Next-state values for the backpressure phase and the token counter.
  always_comb begin
    phase_d       = (phase_q == PH_W'(READY_PERIOD - 1)) ? '0 : phase_q + 1'b1;
    token_count_d = token_count_q + 1'b1;
    // Compared on the widened count so a bound equal to 2^CNT_WIDTH still terminates.
    last_xfer     = xfer && (NUM_TOKENS != 0) && ((int'(token_count_q) + 1) == NUM_TOKENS);
  end

  // Sink FSM with all status registers; reset overrides any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      token_count_q <= '0;
      mismatch_q    <= 1'b0;
      first_bad_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          phase_q <= phase_d;
          if (xfer) begin
            token_count_q <= token_count_d;
            // Only the first offending value is kept for diagnosis.
            if (bad_token && !mismatch_q) begin
              mismatch_q  <= 1'b1;
              first_bad_q <= ins;
            end
            if (last_xfer) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign token_count = token_count_q;
  assign mismatch    = mismatch_q;
  assign first_bad   = first_bad_q;
  assign done        = done_q;

endmodule

// File: tb/tb_handshake_sink_check.sv
// tb/tb_handshake_sink_check.sv - self-checking bench for handshake_sink_check
module tb_handshake_sink_check;

  localparam logic [31:0] EXP    = 32'h77CBF1FA;
  localparam int          NTOK   = 16;
  localparam int          PERIOD = 4;
  localparam int          DUTY   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [15:0] token_count;
  logic        mismatch;
  logic [31:0] first_bad;
  logic        done;

  logic        ins_ready2;
  logic [3:0]  token_count2;
  logic        mismatch2;
  logic [31:0] first_bad2;
  logic        done2;

  always #5 clk = ~clk;

  handshake_sink_check dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .token_count(token_count), .mismatch(mismatch), .first_bad(first_bad), .done(done)
  );

  handshake_sink_check #(
    .NUM_TOKENS(0), .CNT_WIDTH(4), .READY_PERIOD(1), .READY_DUTY(1)
  ) dut2 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready2),
    .token_count(token_count2), .mismatch(mismatch2), .first_bad(first_bad2), .done(done2)
  );

  int          checks = 0;
  int          errors = 0;

  // Reference model: "started" marks the single idle cycle after reset,
  // m_run counts cycles spent accepting, ready follows the duty rule on that count.
  bit          m_started;
  bit          m_done;
  bit          m_mis;
  int          m_run;
  int          m_count;
  logic [31:0] m_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_done    = 0;
    m_mis     = 0;
    m_run     = 0;
    m_count   = 0;
    m_fb      = '0;
  endtask

  task automatic check_outputs();
    chk("token_count", {16'h0, token_count}, 32'(m_count % 65536));
    chk("mismatch", {31'h0, mismatch}, {31'h0, m_mis});
    chk("first_bad", first_bad, m_fb);
    chk("done", {31'h0, done}, {31'h0, m_done});
  endtask

  task automatic do_reset(input logic v);
    rst       = 1'b1;
    ins_valid = v;
    ins       = $urandom;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_ready", {31'h0, ins_ready}, 32'h0);
    check_outputs();
  endtask

  // One clock cycle: present inputs, check ready, advance the model, check outputs.
  task automatic cyc(input logic v, input logic [31:0] d);
    logic exp_rdy;
    ins_valid = v;
    ins       = d;
    exp_rdy   = m_started && !m_done && ((m_run % PERIOD) < DUTY);
    #1;
    chk("ins_ready", {31'h0, ins_ready}, {31'h0, exp_rdy});
    if (!m_started) begin
      m_started = 1;
    end else if (!m_done) begin
      if (v && exp_rdy) begin
        m_count++;
        if (d != EXP && !m_mis) begin
          m_mis = 1;
          m_fb  = d;
        end
        if (m_count == NTOK) m_done = 1;
      end
      m_run++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_data();
    return ($urandom_range(0, 3) == 0) ? $urandom : EXP;
  endfunction

  initial begin
    int c2;

    // Reset, then valid held high with the expected constant.
    do_reset(1'b1);
    repeat (21) cyc(1'b1, EXP);
    chk("count_before_last", {16'h0, token_count}, 32'd15);
    chk("done_before_last", {31'h0, done}, 32'h0);
    cyc(1'b1, EXP);
    chk("count_final", {16'h0, token_count}, 32'd16);
    chk("done_final", {31'h0, done}, 32'h1);
    chk("no_mismatch", {31'h0, mismatch}, 32'h0);

    // Terminal state: valid kept high, everything frozen.
    repeat (10) cyc(1'b1, $urandom);
    chk("done_frozen_count", {16'h0, token_count}, 32'd16);

    // Token 5 wrong, token 9 wrong again: first value must stick.
    do_reset(1'b0);
    for (int g = 0; g < 200 && !m_done; g++)
      cyc(1'b1, (m_count == 4) ? 32'hDEADBEEF : (m_count == 8) ? 32'h0 : EXP);
    chk("tok_done", {31'h0, done}, 32'h1);
    chk("tok_first_bad", first_bad, 32'hDEADBEEF);
    chk("tok_mismatch", {31'h0, mismatch}, 32'h1);

    // Valid toggling against the duty pattern.
    do_reset(1'b0);
    cyc(1'b0, EXP);
    for (int g = 0; g < 7; g++) cyc((g % 2) == 0, EXP);
    chk("toggle_count", {16'h0, token_count}, 32'd4);
    for (int g = 0; g < 200 && !m_done; g++) cyc(m_run % 2 == 0, EXP);
    chk("toggle_done", {31'h0, done}, 32'h1);

    // Random traffic, mismatch on the third accepted token, reset after 7.
    do_reset(1'b0);
    for (int g = 0; g < 300 && m_count < 7; g++)
      cyc($urandom_range(0, 1), (m_count == 2) ? 32'hBAD00001 : rand_data());
    chk("rand_mismatch", {31'h0, mismatch}, 32'h1);
    chk("rand_count7", {16'h0, token_count}, 32'd7);
    do_reset(1'b1);
    cyc(1'b1, EXP);
    for (int g = 0; g < 400 && !m_done; g++) cyc($urandom_range(0, 1), rand_data());
    chk("rand_done", {31'h0, done}, 32'h1);
    repeat (10) cyc(1'b1, rand_data());

    // Unbounded, always-ready configuration with a 4-bit wrapping counter.
    do_reset(1'b1);
    c2 = 0;
    for (int g = 0; g < 40; g++) begin
      ins_valid = 1'b1;
      ins       = EXP;
      #1;
      chk("u2_ready", {31'h0, ins_ready2}, {31'h0, (g != 0)});
      if (g != 0) c2++;
      @(posedge clk);
      #1;
      chk("u2_count", {28'h0, token_count2}, 32'(c2 % 16));
      chk("u2_done", {31'h0, done2}, 32'h0);
    end
    chk("u2_mismatch", {31'h0, mismatch2}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
